// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
// move_sequencer : mouse square clicks -> pick/place strobes for the board
// Revision       : 1.0 - initial release
// ============================================================================
module move_sequencer #(
    parameter int MOVE_CNT_W  = 10,
    parameter int LOOKUP_LAT  = 2,
    parameter bit WHITE_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  click,
    input  logic [5:0]            click_pos,
    input  logic                  cancel,
    input  logic [3:0]            figure_code,
    output logic [5:0]            query_xy,
    output logic [5:0]            figure_position,
    output logic                  pick_piece,
    output logic                  place_piece,
    output logic                  white_turn,
    output logic                  piece_held,
    output logic                  reject,
    output logic                  capture,
    output logic [3:0]            captured_code,
    output logic                  game_over,
    output logic [MOVE_CNT_W-1:0] move_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SRC_WAIT  = 3'd1,
        SRC_CHECK = 3'd2,
        HOLD      = 3'd3,
        DST_WAIT  = 3'd4,
        DST_CHECK = 3'd5,
        PLACE     = 3'd6,
        OVER      = 3'd7
    } state_t;

    localparam int CNT_W = (LOOKUP_LAT > 2) ? $clog2(LOOKUP_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((LOOKUP_LAT > 1) ? (LOOKUP_LAT - 2) : 0);
    // With a single-cycle lookup there is nothing to wait for.
    localparam state_t SRC_NEXT = (LOOKUP_LAT > 1) ? SRC_WAIT : SRC_CHECK;
    localparam state_t DST_NEXT = (LOOKUP_LAT > 1) ? DST_WAIT : DST_CHECK;

    state_t                  state, state_nxt;
    logic [5:0]              src, src_nxt;
    logic [5:0]              dst, dst_nxt;
    logic [5:0]              query_nxt;
    logic [5:0]              fpos_nxt;
    logic                    pick_nxt, place_nxt, reject_nxt, capture_nxt;
    logic [3:0]              cap_code_nxt;
    logic                    held_nxt, over_nxt, white_nxt;
    logic [MOVE_CNT_W-1:0]   count_nxt;
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_nxt;
    logic                    king_hit, king_hit_nxt;

    function automatic logic is_own(input logic [3:0] code, input logic white);
        if (white) begin
            return (code >= 4'd1) && (code <= 4'd6);
        end
        return (code >= 4'd7) && (code <= 4'd12);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            src             <= 6'd0;
            dst             <= 6'd0;
            query_xy        <= 6'd0;
            figure_position <= 6'd0;
            pick_piece      <= 1'b0;
            place_piece     <= 1'b0;
            reject          <= 1'b0;
            capture         <= 1'b0;
            captured_code   <= 4'd0;
            piece_held      <= 1'b0;
            game_over       <= 1'b0;
            white_turn      <= WHITE_FIRST;
            move_count      <= '0;
            wait_cnt        <= '0;
            king_hit        <= 1'b0;
        end else begin
            state           <= state_nxt;
            src             <= src_nxt;
            dst             <= dst_nxt;
            query_xy        <= query_nxt;
            figure_position <= fpos_nxt;
            pick_piece      <= pick_nxt;
            place_piece     <= place_nxt;
            reject          <= reject_nxt;
            capture         <= capture_nxt;
            captured_code   <= cap_code_nxt;
            piece_held      <= held_nxt;
            game_over       <= over_nxt;
            white_turn      <= white_nxt;
            move_count      <= count_nxt;
            wait_cnt        <= wait_cnt_nxt;
            king_hit        <= king_hit_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        src_nxt      = src;
        dst_nxt      = dst;
        query_nxt    = query_xy;
        fpos_nxt     = figure_position;
        pick_nxt     = 1'b0;
        place_nxt    = 1'b0;
        reject_nxt   = 1'b0;
        capture_nxt  = 1'b0;
        cap_code_nxt = captured_code;
        held_nxt     = piece_held;
        over_nxt     = game_over;
        white_nxt    = white_turn;
        count_nxt    = move_count;
        wait_cnt_nxt = wait_cnt;
        king_hit_nxt = king_hit;

        case (state)
            IDLE: begin
                if (click) begin
                    src_nxt      = click_pos;
                    query_nxt    = click_pos;
                    wait_cnt_nxt = WAIT_LOAD;
                    state_nxt    = SRC_NEXT;
                end
            end
            SRC_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = SRC_CHECK;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            SRC_CHECK: begin
                if (is_own(figure_code, white_turn)) begin
                    fpos_nxt  = src;
                    pick_nxt  = 1'b1;
                    held_nxt  = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    reject_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            HOLD: begin
                // Cancel takes priority over a simultaneous click.
                if (cancel) begin
                    fpos_nxt  = src;
                    place_nxt = 1'b1;
                    held_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (click) begin
                    dst_nxt      = click_pos;
                    query_nxt    = click_pos;
                    wait_cnt_nxt = WAIT_LOAD;
                    state_nxt    = DST_NEXT;
                end
            end
            DST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = DST_CHECK;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            DST_CHECK: begin
                if (dst == src) begin
                    fpos_nxt  = src;
                    place_nxt = 1'b1;
                    held_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (is_own(figure_code, white_turn) || (figure_code >= 4'd13)) begin
                    reject_nxt = 1'b1;
                    state_nxt  = HOLD;
                end else begin
                    fpos_nxt     = dst;
                    place_nxt    = 1'b1;
                    held_nxt     = 1'b0;
                    king_hit_nxt = (figure_code == 4'd6) || (figure_code == 4'd12);
                    if (figure_code != 4'd0) begin
                        capture_nxt  = 1'b1;
                        cap_code_nxt = figure_code;
                    end
                    state_nxt = PLACE;
                end
            end
            PLACE: begin
                white_nxt = ~white_turn;
                count_nxt = move_count + 1'b1;
                if (king_hit) begin
                    over_nxt  = 1'b1;
                    state_nxt = OVER;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OVER: begin
                state_nxt = OVER;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
// tb_move_sequencer : directed + randomized bench with an abstract move model
// Revision          : 1.0 - initial release
// ============================================================================
module tb_move_sequencer;

    localparam int MOVE_CNT_W = 10;
    localparam int LAT        = 2;
    localparam int WIN        = LAT + 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  click;
    logic [5:0]            click_pos;
    logic                  cancel;
    logic [3:0]            figure_code;
    logic [5:0]            query_xy;
    logic [5:0]            figure_position;
    logic                  pick_piece;
    logic                  place_piece;
    logic                  white_turn;
    logic                  piece_held;
    logic                  reject;
    logic                  capture;
    logic [3:0]            captured_code;
    logic                  game_over;
    logic [MOVE_CNT_W-1:0] move_count;

    move_sequencer #(
        .MOVE_CNT_W (MOVE_CNT_W),
        .LOOKUP_LAT (LAT),
        .WHITE_FIRST(1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .click          (click),
        .click_pos      (click_pos),
        .cancel         (cancel),
        .figure_code    (figure_code),
        .query_xy       (query_xy),
        .figure_position(figure_position),
        .pick_piece     (pick_piece),
        .place_piece    (place_piece),
        .white_turn     (white_turn),
        .piece_held     (piece_held),
        .reject         (reject),
        .capture        (capture),
        .captured_code  (captured_code),
        .game_over      (game_over),
        .move_count     (move_count)
    );

    always #5 clk = ~clk;

    // Board storage: one register stage gives a two-cycle lookup from query_xy.
    logic [3:0] board [64];
    logic [3:0] lookup_q;
    always @(posedge clk) lookup_q <= board[query_xy];
    assign figure_code = lookup_q;

    // Abstract game model
    bit         m_white;
    int         m_count;
    bit         m_held;
    bit         m_over;
    logic [5:0] m_src;
    logic [3:0] m_cap_code;
    logic [3:0] env_hold;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit owned(input logic [3:0] code, input bit white);
        if (white) return (code >= 1) && (code <= 6);
        return (code >= 7) && (code <= 12);
    endfunction

    task automatic init_board(input bit rnd);
        logic [3:0] v;
        for (int i = 0; i < 64; i++) begin
            if (rnd) begin
                v = 4'($urandom_range(0, 15));
                if ((v == 4'd6 || v == 4'd12) && $urandom_range(0, 3) != 0) v = 4'd0;
                board[i] = v;
            end else begin
                board[i] = 4'd0;
            end
        end
        if (!rnd) begin
            for (int c = 0; c < 8; c++) begin
                board[8 + c]  = 4'd7;
                board[48 + c] = 4'd1;
            end
            board[0] = 4'd10; board[1] = 4'd8; board[2] = 4'd9; board[3] = 4'd11;
            board[4] = 4'd12; board[5] = 4'd9; board[6] = 4'd8; board[7] = 4'd10;
            board[56] = 4'd4; board[57] = 4'd2; board[58] = 4'd3; board[59] = 4'd5;
            board[60] = 4'd6; board[61] = 4'd3; board[62] = 4'd2; board[63] = 4'd4;
        end
    endtask

    task automatic do_reset(input bit rnd);
        @(negedge clk);
        rst    = 1'b1;
        click  = 1'b0;
        cancel = 1'b0;
        #1;
        check("rst_query_xy", 32'(query_xy), 32'd0);
        check("rst_figure_position", 32'(figure_position), 32'd0);
        check("rst_pick", 32'(pick_piece), 32'd0);
        check("rst_place", 32'(place_piece), 32'd0);
        check("rst_reject", 32'(reject), 32'd0);
        check("rst_capture", 32'(capture), 32'd0);
        check("rst_piece_held", 32'(piece_held), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_captured_code", 32'(captured_code), 32'd0);
        check("rst_move_count", 32'(move_count), 32'd0);
        check("rst_white_turn", 32'(white_turn), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        init_board(rnd);
        m_white    = 1'b1;
        m_count    = 0;
        m_held     = 1'b0;
        m_over     = 1'b0;
        m_src      = 6'd0;
        m_cap_code = 4'd0;
    endtask

    // kind: 0 none, 1 pick, 2 place, 3 reject
    task automatic do_op(input bit is_cancel, input logic [5:0] pos, input bit dbl);
        int         exp_type, exp_k;
        logic [5:0] exp_fp;
        bit         exp_cap;
        logic [3:0] code;
        int         n_pick, n_place, n_rej, n_cap, n_both, strobe_k, cap_k;
        logic [5:0] fp_seen;

        exp_type = 0; exp_fp = 6'd0; exp_cap = 1'b0;
        exp_k = is_cancel ? 1 : LAT + 1;
        code = board[pos];
        n_pick = 0; n_place = 0; n_rej = 0; n_cap = 0; n_both = 0;
        strobe_k = 0; cap_k = 0; fp_seen = 6'd0;

        if (!m_over) begin
            if (is_cancel) begin
                if (m_held) begin
                    exp_type = 2; exp_fp = m_src; m_held = 1'b0;
                end
            end else if (!m_held) begin
                if (owned(code, m_white)) begin
                    exp_type = 1; exp_fp = pos; m_held = 1'b1; m_src = pos;
                end else begin
                    exp_type = 3;
                end
            end else if (pos == m_src) begin
                exp_type = 2; exp_fp = m_src; m_held = 1'b0;
            end else if (owned(code, m_white) || code >= 4'd13) begin
                exp_type = 3;
            end else begin
                exp_type = 2; exp_fp = pos; m_held = 1'b0;
                if (code != 4'd0) begin
                    exp_cap = 1'b1;
                    m_cap_code = code;
                    if (code == 4'd6 || code == 4'd12) m_over = 1'b1;
                end
                m_white = !m_white;
                m_count = (m_count + 1) % (1 << MOVE_CNT_W);
            end
        end

        @(negedge clk);
        click     = !is_cancel;
        cancel    = is_cancel;
        click_pos = pos;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            click  = dbl && (k == 1);
            cancel = 1'b0;
            if (pick_piece && place_piece) n_both++;
            if (pick_piece) begin
                n_pick++; strobe_k = k; fp_seen = figure_position;
                env_hold = board[figure_position];
                board[figure_position] = 4'd0;
            end
            if (place_piece) begin
                n_place++; strobe_k = k; fp_seen = figure_position;
                board[figure_position] = env_hold;
            end
            if (reject) begin
                n_rej++; strobe_k = k;
            end
            if (capture) begin
                n_cap++; cap_k = k;
            end
        end

        check("pick_count", 32'(n_pick), 32'(exp_type == 1));
        check("place_count", 32'(n_place), 32'(exp_type == 2));
        check("reject_count", 32'(n_rej), 32'(exp_type == 3));
        check("capture_count", 32'(n_cap), 32'(exp_cap));
        check("pick_place_overlap", 32'(n_both), 32'd0);
        if (exp_type != 0) check("strobe_latency", 32'(strobe_k), 32'(exp_k));
        if (exp_type == 1 || exp_type == 2) check("figure_position", 32'(fp_seen), 32'(exp_fp));
        if (exp_cap) check("capture_latency", 32'(cap_k), 32'(exp_k));
        check("white_turn", 32'(white_turn), 32'(m_white));
        check("move_count", 32'(move_count), 32'(m_count));
        check("piece_held", 32'(piece_held), 32'(m_held));
        check("game_over", 32'(game_over), 32'(m_over));
        check("captured_code", 32'(captured_code), 32'(m_cap_code));
    endtask

    initial begin
        bit         cn;
        logic [5:0] p;
        rst       = 1'b0;
        click     = 1'b0;
        cancel    = 1'b0;
        click_pos = 6'd0;
        env_hold  = 4'd0;

        // Simple pawn move, then a move of the wrong colour.
        do_reset(1'b0);
        do_op(1'b0, 6'h31, 1'b0);
        do_op(1'b0, 6'h21, 1'b0);
        do_reset(1'b0);
        do_op(1'b0, 6'h08, 1'b0);

        // Own-piece target is refused, then cancel returns the piece.
        do_op(1'b0, 6'h31, 1'b0);
        do_op(1'b0, 6'h30, 1'b0);
        do_op(1'b1, 6'h00, 1'b0);

        // Capture of a code-9 piece, a black reply, then a king capture.
        board[6'h21] = 4'd9;
        do_op(1'b0, 6'h31, 1'b0);
        do_op(1'b0, 6'h21, 1'b0);
        do_op(1'b0, 6'h08, 1'b0);
        do_op(1'b0, 6'h10, 1'b0);
        board[6'h29] = 4'd12;
        do_op(1'b0, 6'h21, 1'b0);
        do_op(1'b0, 6'h29, 1'b0);
        do_op(1'b0, 6'h36, 1'b0);
        do_op(1'b1, 6'h00, 1'b0);
        do_reset(1'b0);

        // Reset while holding, and a repeated click during the source lookup.
        do_op(1'b0, 6'h31, 1'b0);
        do_reset(1'b0);
        do_op(1'b0, 6'h31, 1'b1);
        do_op(1'b0, 6'h31, 1'b0);

        do_reset(1'b1);
        for (int i = 0; i < 300; i++) begin
            if (m_over && $urandom_range(0, 2) == 0) begin
                do_reset(1'b1);
            end else begin
                cn = ($urandom_range(0, 4) == 0);
                p  = 6'($urandom_range(0, 63));
                if (m_held && $urandom_range(0, 5) == 0) p = m_src;
                do_op(cn, p, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
